// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC and the IF/ID register.
// It issues one word request at a time over req/gnt/rvalid and feeds pc/inst to ID.
// A one-entry skid buffer catches a response that lands while ID is stalled.
// Wrong-path responses are dropped, and NOP bubbles are driven to ID when there is no valid instruction.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        br_i,
  input  logic [31:0] branch_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        discard_q, discard_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;

  logic        fire;        // request accepted this cycle
  logic        resp;        // response for the outstanding request
  logic        fresh;       // response that belongs to the current path
  logic        branch_take; // redirect that is not masked by a stall

  assign imem_addr_o = fetch_pc_q;
  assign if_pc_o     = if_pc_q;
  assign if_inst_o   = if_inst_q;
  assign if_valid_o  = if_valid_q;

  // Handshake, fetch PC sequencing, skid buffer and IF/ID register next-state
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    discard_d    = discard_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;
    if_valid_d   = if_valid_q;

    // A full skid buffer holds off new requests so at most one extra instruction is in flight.
    imem_req_o  = (state_q == S_REQ) && !skid_valid_q && !reset;
    fire        = imem_req_o && imem_gnt_i;
    resp        = (state_q == S_WAIT) && imem_rvalid_i;
    fresh       = resp && !discard_q;
    branch_take = br_i && !stall_i;

    if (fire) begin
      state_d  = S_WAIT;
      req_pc_d = fetch_pc_q;
    end
    if (resp) begin
      state_d = S_REQ;
      if (discard_q) discard_d = 1'b0;
    end

    if (branch_take) begin
      fetch_pc_d = branch_addr_i & 32'hFFFF_FFFC;
      // Mark only a request still outstanding after this cycle; a response
      // arriving now is already dropped by the branch taking priority.
      if (fire || ((state_q == S_WAIT) && !imem_rvalid_i)) discard_d = 1'b1;
    end else if (fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (stall_i) begin
      if (fresh) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = req_pc_q;
        skid_inst_d  = imem_rdata_i;
      end
    end else if (br_i) begin
      if_inst_d    = NOP_INST;
      if_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if_pc_d      = skid_pc_q;
      if_inst_d    = skid_inst_q;
      if_valid_d   = 1'b1;
      skid_valid_d = 1'b0;
    end else if (fresh) begin
      if_pc_d    = req_pc_q;
      if_inst_d  = imem_rdata_i;
      if_valid_d = 1'b1;
    end else begin
      if_inst_d  = NOP_INST;
      if_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset abandons any outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= RESET_PC;
      discard_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_inst_q  <= NOP_INST;
      if_pc_q      <= 32'h0;
      if_inst_q    <= NOP_INST;
      if_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      discard_q    <= discard_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      if_pc_q      <= if_pc_d;
      if_inst_q    <= if_inst_d;
      if_valid_q   <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit. The bench drives memory
// responses by hand, one cycle per row. Each row holds the expected request/address
// for that cycle and the expected IF/ID outputs after the clock edge.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        br_i;
  logic [31:0] branch_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  int tests_run;
  int tests_failed;

  if_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .br_i         (br_i),
    .branch_addr_i(branch_addr_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .if_pc_o      (if_pc_o),
    .if_inst_o    (if_inst_o),
    .if_valid_o   (if_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] baddr;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic        chk_addr;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic stall, input logic br, input logic [31:0] baddr,
                     input logic gnt, input logic rv, input logic [31:0] rdata,
                     input logic e_req, input logic chk_addr, input logic [31:0] e_addr,
                     input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_valid);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.baddr = baddr;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.e_req = e_req; v.chk_addr = chk_addr; v.e_addr = e_addr;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_valid = e_valid;
    vecs.push_back(v);
  endtask

  task automatic check32(input string tag, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s row %0d: got %h, expected %h", tag, idx, act, exp);
    end
  endtask

  // Apply one cycle of stimulus and check combinational then registered outputs.
  task automatic step(input int idx, input vec_t v);
    @(negedge clk);
    reset = v.rst; stall_i = v.stall; br_i = v.br; branch_addr_i = v.baddr;
    imem_gnt_i = v.gnt; imem_rvalid_i = v.rv; imem_rdata_i = v.rdata;
    #1;
    check32("imem_req", idx, {31'd0, imem_req_o}, {31'd0, v.e_req});
    if (v.chk_addr) check32("imem_addr", idx, imem_addr_o, v.e_addr);
    @(posedge clk);
    #1;
    check32("if_pc", idx, if_pc_o, v.e_pc);
    check32("if_inst", idx, if_inst_o, v.e_inst);
    check32("if_valid", idx, {31'd0, if_valid_o}, {31'd0, v.e_valid});
    $display("[TB] row %0d: req=%0d addr=%h -> pc=%h inst=%h valid=%0d",
             idx, v.e_req, v.e_addr, if_pc_o, if_inst_o, if_valid_o);
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    vec_t hs;
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1; stall_i = 0; br_i = 0; branch_addr_i = 0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;

    //   rst st br baddr         gnt rv rdata          req ca addr          pc            inst          v
    // reset
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,         0, 0, 32'h0,         32'h0,        NOP,          0);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,         0, 1, 32'h0,         32'h0,        NOP,          0);
    // T1: sequential fetch, one instruction per 2 cycles
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h0,         32'h0,        NOP,          0);
    add(0, 0, 0, 32'h0,        1, 1, 32'h100,       0, 1, 32'h4,         32'h0,        32'h100,      1);
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h4,         32'h0,        NOP,          0);
    add(0, 0, 0, 32'h0,        1, 1, 32'h101,       0, 1, 32'h8,         32'h4,        32'h101,      1);
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h8,         32'h4,        NOP,          0);
    add(0, 0, 0, 32'h0,        1, 1, 32'h102,       0, 1, 32'hC,         32'h8,        32'h102,      1);
    // T2: stall while response for 0xC arrives -> skid, then drain
    add(0, 1, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'hC,         32'h8,        32'h102,      1);
    add(0, 1, 0, 32'h0,        1, 1, 32'h103,       0, 1, 32'h10,        32'h8,        32'h102,      1);
    add(0, 1, 0, 32'h0,        1, 0, 32'h0,         0, 1, 32'h10,        32'h8,        32'h102,      1);
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 1, 32'h10,        32'hC,        32'h103,      1);
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h10,        32'hC,        NOP,          0);
    // T3: branch during S_WAIT, stale response dropped, refetch at 0x40
    add(0, 0, 1, 32'h42,       1, 0, 32'h0,         0, 1, 32'h14,        32'hC,        NOP,          0);
    add(0, 0, 0, 32'h0,        1, 1, 32'hDEAD,      0, 1, 32'h40,        32'hC,        NOP,          0);
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h40,        32'hC,        NOP,          0);
    add(0, 0, 0, 32'h0,        1, 1, 32'h140,       0, 1, 32'h44,        32'h40,       32'h140,      1);
    // T4: branch with stall is ignored, sequential fetch continues
    add(0, 1, 1, 32'h80,       1, 0, 32'h0,         1, 1, 32'h44,        32'h40,       32'h140,      1);
    add(0, 0, 0, 32'h0,        1, 1, 32'h141,       0, 1, 32'h48,        32'h44,       32'h141,      1);
    // T5: grant withheld four cycles
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h48,        32'h44,       NOP,          0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h48,        32'h44,       NOP,          0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h48,        32'h44,       NOP,          0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h48,        32'h44,       NOP,          0);
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h48,        32'h44,       NOP,          0);
    // T6: reset in S_WAIT, late rvalid ignored, restart at RESET_PC
    add(1, 0, 0, 32'h0,        1, 0, 32'h0,         0, 1, 32'h4C,        32'h0,        NOP,          0);
    add(0, 0, 0, 32'h0,        0, 1, 32'hBAD0,      1, 1, 32'h0,         32'h0,        NOP,          0);
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h0,         32'h0,        NOP,          0);
    add(0, 0, 0, 32'h0,        1, 1, 32'h200,       0, 1, 32'h4,         32'h0,        32'h200,      1);
    // branch together with req&gnt: grant consumed, its response dropped
    add(0, 0, 1, 32'h1000,     1, 0, 32'h0,         1, 1, 32'h4,         32'h0,        NOP,          0);
    add(0, 0, 0, 32'h0,        1, 1, 32'hBAD1,      0, 1, 32'h1000,      32'h0,        NOP,          0);
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'h1000,      32'h0,        NOP,          0);
    // branch together with rvalid: branch wins; target low bits cleared
    add(0, 0, 1, 32'hFFFF_FFFF, 1, 1, 32'h300,      0, 1, 32'h1004,      32'h0,        NOP,          0);
    // fetch at 0xFFFF_FFFC wraps to 0
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h0,        NOP,          0);
    add(0, 0, 0, 32'h0,        1, 1, 32'h400,       0, 1, 32'h0,         32'hFFFF_FFFC, 32'h400,     1);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 1, 32'h0,         32'hFFFF_FFFC, NOP,         0);

    for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

    // Hand-written sequence: a skid entry is flushed by a branch after the stall releases.
    hs = '{rst:0, stall:1, br:0, baddr:0, gnt:1, rv:0, rdata:0,
           e_req:1, chk_addr:1, e_addr:32'h0, e_pc:32'hFFFF_FFFC, e_inst:NOP, e_valid:0};
    step(100, hs);
    hs = '{rst:0, stall:1, br:0, baddr:0, gnt:1, rv:1, rdata:32'h500,
           e_req:0, chk_addr:1, e_addr:32'h4, e_pc:32'hFFFF_FFFC, e_inst:NOP, e_valid:0};
    step(101, hs);
    hs = '{rst:0, stall:0, br:1, baddr:32'h20, gnt:1, rv:0, rdata:0,
           e_req:0, chk_addr:1, e_addr:32'h4, e_pc:32'hFFFF_FFFC, e_inst:NOP, e_valid:0};
    step(102, hs);
    hs = '{rst:0, stall:0, br:0, baddr:0, gnt:1, rv:0, rdata:0,
           e_req:1, chk_addr:1, e_addr:32'h20, e_pc:32'hFFFF_FFFC, e_inst:NOP, e_valid:0};
    step(103, hs);
    hs = '{rst:0, stall:0, br:0, baddr:0, gnt:1, rv:1, rdata:32'h600,
           e_req:0, chk_addr:1, e_addr:32'h24, e_pc:32'h20, e_inst:32'h600, e_valid:1};
    step(104, hs);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
